dm_responder: RTL and testbench
===============================

# dm_responder

Data-memory responder for the pipelined CPU's data port: the memory end of the `m_data_*` interface that the core drives from its M stage. Serves combinational word reads, applies byte-enabled stores, and zero-clears its array after reset with a walking clear FSM. Every accepted store is logged into a store-trace FIFO that the testbench drains over a valid/ready handshake.

## Interface
Parameters:
- `ADDR_W`, 12: word-address width; array holds 2^ADDR_W 32-bit words at byte addresses 0 .. 4·2^ADDR_W−1.
- `TRACE_DEPTH`, 8: store-trace FIFO entries, power of two ≥ 2.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `m_data_addr`  in  32  byte address from the core's M stage.
- `m_data_wdata`  in  32  store data, byte lanes aligned to the address word.
- `m_data_byteen`  in  4  per-byte write enables; 4'b0000 means no store.
- `m_inst_addr`  in  32  PC of the instruction in M, captured into trace.
- `m_data_rdata`  out  32  read word at `m_data_addr`.
- `init_done`  out  1  high once the clear walk has finished.
- `trace_valid`  out  1  FIFO non-empty.
- `trace_ready`  in  1  consumer accepts head entry.
- `trace_pc`, `trace_addr`, `trace_wdata`  out  32 each  head entry; `trace_addr` is word-aligned (bits [1:0] = 0).
- `trace_byteen`  out  4  head entry byte enables.
- `err_oob`  out  1  sticky: store outside the array.
- `err_early`  out  1  sticky: store attempted before `init_done`.
- `err_overflow`  out  1  sticky: store dropped from trace because FIFO full.

## Operation
- Clear FSM, states CLEAR and READY. `reset` forces CLEAR with `clr_idx`=0. In CLEAR, each cycle writes 0 to `mem[clr_idx]` and increments. The cycle `clr_idx`=2^ADDR_W−1 is written, the FSM moves to READY. READY holds until `reset`.
- Clearing runs whether `reset` is high or low. Re-asserting `reset` mid-walk restarts at index 0.
- Read: `m_data_rdata` = `mem[m_data_addr[ADDR_W+1:2]]` when in range and READY, else 0. Low address bits are ignored; the core performs lane extraction.
- Store condition: `m_data_byteen`≠0 while `reset` is low.
  - In CLEAR: the store is dropped and `err_early` is set.
  - In READY and out of range (`m_data_addr[31:ADDR_W+2]`≠0): the store is dropped and `err_oob` is set.
  - Otherwise: each byte i with `byteen[i]`=1 gets `wdata[8i+7:8i]`. Other bytes are unchanged.
- Trace: every accepted store pushes {`m_inst_addr`, word-aligned addr, `m_data_wdata`, `m_data_byteen`}. Dropped stores are not traced.
- Pop on `trace_valid && trace_ready`.
- Push while full with no pop: entry dropped, `err_overflow` set.
- Push while full with a pop in the same cycle: both take effect; count stays at full.
- Push and pop on an empty FIFO: the push lands and the count becomes 1. There is no bypass.
- Pointers wrap modulo TRACE_DEPTH. Count is tracked with an extra bit so full and empty are distinct.
- Reset values: FIFO empty, `trace_valid`=0, all `err_*`=0, `init_done`=0. `m_data_rdata`=0 while in CLEAR. Array contents are not reset directly; the clear walk zeroes them.

## Timing
- Read latency 0: `m_data_rdata` is combinational from `m_data_addr`, matching the core's M→W capture.
- A store at edge N is visible to a read of the same word from cycle N+1. A same-cycle read returns the old word.
- The clear walk takes exactly 2^ADDR_W cycles from the last `reset`-high edge. `init_done` rises the cycle after the final clear write.
- A trace entry pushed at edge N gives `trace_valid`=1 from cycle N+1. Head data is stable while `trace_valid && !trace_ready`.
- Error flags assert the cycle after the offending edge and hold until `reset`.

## Structure
- Shared package: `DM_ADDR_W` default, trace-entry struct (pc, addr, wdata, byteen; 100 bits), clear-FSM state enum.
- One sub-module, `trace_fifo`: a parameterised synchronous FIFO with push/pop, full/empty and drop-on-full. The array and the FSM stay in `dm_responder`.

## Test plan
- Hold `reset` 3 cycles, release, wait 2^ADDR_W cycles → `init_done`=1. Read 0x0, 0x100 and 0x3FFC → all 0. With ADDR_W=4: `init_done` rises exactly 16 cycles after the last reset edge.
- Store addr 0x10, data 0xAABBCCDD, byteen 4'b1111, pc 0x3000. Next cycle store data 0x11223344, byteen 4'b0010 → read 0x10 = 0xAABB33DD. Trace pops {0x3000, 0x10, 0xAABBCCDD, 4'hF}, then the second entry.
- Store at 0x4000 with ADDR_W=12 → `err_oob`=1, no trace push, read 0x0 unchanged.
- Hold `trace_ready`=0 and issue 9 stores with TRACE_DEPTH=8 → `err_overflow`=1 and 8 entries drain in order. Then at full, assert `trace_ready` together with a store → count stays 8 and the newest entry is retained.
- Release `reset` and store 2 cycles later (mid-clear) → `err_early`=1, no trace push. Assert `reset` again mid-walk → walk restarts and `init_done` rises 2^ADDR_W cycles after release.

Source files
------------

// File: rtl/dm_responder_pkg.sv
// Shared types for the data-memory responder: trace entry layout and clear-FSM states.
package dm_responder_pkg;

  localparam int DM_ADDR_W = 12;

  // One logged store: 32 + 32 + 32 + 4 = 100 bits.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } dm_trace_t;

  typedef enum logic {
    DM_CLEAR = 1'b0,
    DM_READY = 1'b1
  } dm_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous store-trace FIFO with drop-on-full; a pop in the same cycle frees room for a push.
module trace_fifo
  import dm_responder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push_i,
  input  dm_trace_t push_data_i,
  input  logic      pop_i,
  output logic      valid_o,
  output dm_trace_t head_o,
  output logic      drop_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  dm_trace_t     mem_q [DEPTH];

  logic empty, full, pop_en, push_en;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign pop_en  = pop_i && !empty;
  assign push_en = push_i && (!full || pop_en);
  assign drop_o  = push_i && full && !pop_en;
  assign valid_o = !empty;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + (PW+1)'(push_en) - (PW+1)'(pop_en);
    end
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/dm_responder.sv
// Memory end of the core's data port: combinational reads, byte-enabled stores,
// post-reset zero-clear walk, and a store-trace FIFO.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int ADDR_W      = DM_ADDR_W,
  parameter int TRACE_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        init_done,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_wdata,
  output logic [3:0]  trace_byteen,
  output logic        err_oob,
  output logic        err_early,
  output logic        err_overflow
);

  localparam int WORDS = 2 ** ADDR_W;

  dm_state_t         state_q;
  logic [ADDR_W-1:0] clr_idx_q;
  logic              init_done_q;
  logic              err_oob_q, err_early_q, err_overflow_q;
  logic [31:0]       mem_q [WORDS];

  logic [ADDR_W-1:0] word_idx;
  logic              in_range, store_req, store_ok, trace_drop;
  logic              unused_addr_lo;
  dm_trace_t         push_entry, head_entry;

  assign word_idx       = m_data_addr[ADDR_W+1:2];
  assign in_range       = (m_data_addr[31:ADDR_W+2] == '0);
  assign store_req      = (m_data_byteen != 4'b0000) && !reset;
  assign store_ok       = store_req && (state_q == DM_READY) && in_range;
  assign unused_addr_lo = ^m_data_addr[1:0];

  assign m_data_rdata = ((state_q == DM_READY) && in_range) ? mem_q[word_idx] : '0;

  // Clear walk: one word per cycle from index 0; last index hands over to READY.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= DM_CLEAR;
      clr_idx_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        DM_CLEAR: begin
          clr_idx_q <= clr_idx_q + ADDR_W'(1);
          if (clr_idx_q == '1) begin
            state_q     <= DM_READY;
            init_done_q <= 1'b1;
          end
        end
        DM_READY: state_q <= DM_READY;
        default:  state_q <= DM_CLEAR;
      endcase
    end
  end

  // Array writes: clearing owns the array until READY, then per-byte stores.
  always_ff @(posedge clk) begin
    if (state_q == DM_CLEAR) begin
      mem_q[clr_idx_q] <= '0;
    end else if (store_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (m_data_byteen[i]) mem_q[word_idx][8*i +: 8] <= m_data_wdata[8*i +: 8];
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_oob_q      <= 1'b0;
      err_early_q    <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      if (store_req && (state_q == DM_CLEAR))             err_early_q    <= 1'b1;
      if (store_req && (state_q == DM_READY) && !in_range) err_oob_q      <= 1'b1;
      if (trace_drop)                                      err_overflow_q <= 1'b1;
    end
  end

  assign push_entry = '{pc:     m_inst_addr,
                        addr:   {m_data_addr[31:2], 2'b00},
                        wdata:  m_data_wdata,
                        byteen: m_data_byteen};

  trace_fifo #(.DEPTH(TRACE_DEPTH)) u_trace_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (store_ok),
    .push_data_i (push_entry),
    .pop_i       (trace_ready),
    .valid_o     (trace_valid),
    .head_o      (head_entry),
    .drop_o      (trace_drop)
  );

  assign trace_pc     = head_entry.pc;
  assign trace_addr   = head_entry.addr;
  assign trace_wdata  = head_entry.wdata;
  assign trace_byteen = head_entry.byteen;

  assign init_done    = init_done_q;
  assign err_oob      = err_oob_q;
  assign err_early    = err_early_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder with ADDR_W=12, TRACE_DEPTH=8.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m_data_addr = '0;
  logic [31:0] m_data_wdata = '0;
  logic [3:0]  m_data_byteen = '0;
  logic [31:0] m_inst_addr = '0;
  logic        trace_ready = 1'b0;
  logic [31:0] m_data_rdata, trace_pc, trace_addr, trace_wdata;
  logic [3:0]  trace_byteen;
  logic        init_done, trace_valid, err_oob, err_early, err_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  dm_responder #(.ADDR_W(12), .TRACE_DEPTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_inst_addr   (m_inst_addr),
    .m_data_rdata  (m_data_rdata),
    .init_done     (init_done),
    .trace_valid   (trace_valid),
    .trace_ready   (trace_ready),
    .trace_pc      (trace_pc),
    .trace_addr    (trace_addr),
    .trace_wdata   (trace_wdata),
    .trace_byteen  (trace_byteen),
    .err_oob       (err_oob),
    .err_early     (err_early),
    .err_overflow  (err_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] pc);
    m_data_addr   = a;
    m_data_wdata  = d;
    m_data_byteen = be;
    m_inst_addr   = pc;
  endtask

  task automatic idle();
    m_data_byteen = 4'b0000;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    m_data_addr = a;
    #1;
    chk(tag, m_data_rdata, exp);
  endtask

  task automatic trace_chk(input string tag, input logic [31:0] pc, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be);
    chk({tag, "_valid"}, {31'b0, trace_valid}, 32'd1);
    chk({tag, "_pc"}, trace_pc, pc);
    chk({tag, "_addr"}, trace_addr, a);
    chk({tag, "_wdata"}, trace_wdata, d);
    chk({tag, "_be"}, {28'b0, trace_byteen}, {28'b0, be});
  endtask

  initial begin
    // Reset for 3 cycles; the third edge is the last reset-high edge.
    reset = 1'b1;
    step(); step(); step();
    chk("rst_init_done", {31'b0, init_done}, 32'd0);
    chk("rst_trace_valid", {31'b0, trace_valid}, 32'd0);
    chk("rst_errs", {29'b0, err_oob, err_early, err_overflow}, 32'd0);
    reset = 1'b0;
    rd_chk("rst_rdata", 32'h0, 32'h0);

    // Clear walk of 4096 words.
    repeat (4095) step();
    chk("walk_not_done_4095", {31'b0, init_done}, 32'd0);
    rd_chk("walk_rdata_clear", 32'h0, 32'h0);
    step();
    chk("walk_done_4096", {31'b0, init_done}, 32'd1);
    rd_chk("rd_0x0", 32'h0, 32'h0);
    rd_chk("rd_0x100", 32'h100, 32'h0);
    rd_chk("rd_0x3ffc", 32'h3FFC, 32'h0);

    // Full-word store then a single-lane store at an unaligned address in the same word.
    store(32'h10, 32'hAABBCCDD, 4'b1111, 32'h3000);
    #1;
    chk("same_cycle_old_word", m_data_rdata, 32'h0);
    step();
    chk("trace_valid_next_cycle", {31'b0, trace_valid}, 32'd1);
    store(32'h12, 32'h11223344, 4'b0010, 32'h3004);
    step();
    idle();
    rd_chk("merge_0x10", 32'h10, 32'hAABB33DD);
    trace_chk("tr0", 32'h3000, 32'h10, 32'hAABBCCDD, 4'hF);
    trace_ready = 1'b1;
    step();
    trace_chk("tr1", 32'h3004, 32'h10, 32'h11223344, 4'h2);
    step();
    trace_ready = 1'b0;
    chk("tr_empty", {31'b0, trace_valid}, 32'd0);

    // Out-of-range store.
    store(32'h4000, 32'hDEADBEEF, 4'b1111, 32'h3008);
    step();
    idle();
    chk("oob_flag", {31'b0, err_oob}, 32'd1);
    chk("oob_no_trace", {31'b0, trace_valid}, 32'd0);
    chk("oob_no_early", {31'b0, err_early}, 32'd0);
    rd_chk("oob_word0_unchanged", 32'h0, 32'h0);

    // Nine stores with the consumer stalled.
    for (int i = 0; i < 9; i++) begin
      store(32'h20 + 32'(4 * i), 32'h100 + 32'(i), 4'b1111, 32'h4000 + 32'(4 * i));
      step();
      if (i == 7) chk("ovf_not_yet", {31'b0, err_overflow}, 32'd0);
    end
    idle();
    chk("ovf_flag", {31'b0, err_overflow}, 32'd1);
    chk("ovf_head", trace_wdata, 32'h100);
    rd_chk("ovf_store_still_written", 32'h40, 32'h108);

    // Push and pop together at full.
    store(32'h60, 32'h200, 4'b1111, 32'h5000);
    trace_ready = 1'b1;
    step();
    idle();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_%0d", i), trace_wdata, (i < 7) ? 32'h101 + 32'(i) : 32'h200);
      step();
    end
    chk("drain_empty", {31'b0, trace_valid}, 32'd0);
    rd_chk("rd_0x60", 32'h60, 32'h200);

    // Push with ready high on an empty FIFO: no bypass.
    store(32'h80, 32'h55, 4'b0001, 32'h6000);
    #1;
    chk("nobypass_before", {31'b0, trace_valid}, 32'd0);
    step();
    idle();
    trace_chk("nobypass", 32'h6000, 32'h80, 32'h55, 4'h1);
    step();
    chk("nobypass_popped", {31'b0, trace_valid}, 32'd0);
    trace_ready = 1'b0;

    // Reset clears the sticky flags; a store during the walk is early.
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_errs", {29'b0, err_oob, err_early, err_overflow}, 32'd0);
    chk("rst2_init_done", {31'b0, init_done}, 32'd0);
    step(); step();
    store(32'h10, 32'h12345678, 4'b1111, 32'h7000);
    step();
    idle();
    chk("early_flag", {31'b0, err_early}, 32'd1);
    chk("early_no_trace", {31'b0, trace_valid}, 32'd0);

    // Reset again mid-walk: walk restarts from the new release.
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst3_early_cleared", {31'b0, err_early}, 32'd0);
    repeat (4095) step();
    chk("restart_not_done_4095", {31'b0, init_done}, 32'd0);
    step();
    chk("restart_done_4096", {31'b0, init_done}, 32'd1);
    rd_chk("restart_cleared_0x10", 32'h10, 32'h0);
    rd_chk("restart_cleared_0x40", 32'h40, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
